// File: rtl/caixa_pkg.sv
// Shared types and helpers for the water-tank controller.
// Probe vectors are {H,M,L}; levels and fault codes are 2-bit codes.
package caixa_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FILLING,
      FULL,
      FAULT
   } estado_t;

   localparam logic [1:0] CRIT  = 2'b00;
   localparam logic [1:0] BAIXO = 2'b01;
   localparam logic [1:0] MEDIO = 2'b10;
   localparam logic [1:0] ALTO  = 2'b11;

   localparam logic [1:0] NONE   = 2'b00;
   localparam logic [1:0] INCONS = 2'b01;
   localparam logic [1:0] SECO   = 2'b10;

   // Water can only wet a probe if every probe below it is wet too.
   function automatic logic consistente(input logic [2:0] v);
      return (v == 3'b000) || (v == 3'b001) ||
             (v == 3'b011) || (v == 3'b111);
   endfunction

   function automatic logic [1:0] nivel_de(input logic [2:0] v);
      logic [1:0] n;
      case (v)
         3'b001:  n = BAIXO;
         3'b011:  n = MEDIO;
         3'b111:  n = ALTO;
         default: n = CRIT;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/controle_caixa_filtro_sonda.sv
// Two-flop synchronizer plus debounce for the {H,M,L} probe vector.
// prox is the value vec takes at the next edge, so users can register it.
module filtro_sonda #(
   parameter int DEB_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] raw,
   output logic [2:0] vec,
   output logic [2:0] prox
);

   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic [2:0]    s1;
   logic [2:0]    s2;
   logic [2:0]    s2_d;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_inc;
   logic          carga;

   // A fresh change of the synced vector starts a new run of length 1.
   always_comb begin
      cnt_inc = (s2 != s2_d) ? CW'(1) : cnt + CW'(1);
      carga   = (s2 != vec) && (cnt_inc == CW'(DEB_CYCLES));
      prox    = carga ? s2 : vec;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1   <= '0;
         s2   <= '0;
         s2_d <= '0;
         vec  <= '0;
         cnt  <= '0;
      end else begin
         s1   <= raw;
         s2   <= s1;
         s2_d <= s2;
         vec  <= prox;
         if ((s2 == vec) || carga)
            cnt <= '0;
         else
            cnt <= cnt_inc;
      end
   end

endmodule

// File: rtl/controle_caixa.sv
// Water-tank controller: debounced level, hysteretic inlet valve,
// pump grant and latched fault reporting.
module controle_caixa
   import caixa_pkg::*;
#(
   parameter int DEB_CYCLES   = 16,
   parameter int FILL_TIMEOUT = 1000000,
   parameter int CNT_W        = 20
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       H,
   input  logic       M,
   input  logic       L,
   input  logic       REQ_IRR,
   input  logic       ACK_FLT,
   output logic       VE,
   output logic       GNT_IRR,
   output logic       AL,
   output logic       ERRO,
   output logic [1:0] FLT_CODE,
   output logic [1:0] NIVEL
);

   estado_t      estado;
   logic [2:0]   vec;
   logic [2:0]   prox;
   logic         inc_ant;
   logic [CNT_W-1:0] fill_cnt;

   logic [1:0]   nivel_nx;
   logic         sobe;
   logic         incons;
   logic         timeout;
   logic         baixo;

   filtro_sonda #(
      .DEB_CYCLES(DEB_CYCLES)
   ) u_filtro (
      .clk (CLK),
      .rst (RST),
      .raw ({H, M, L}),
      .vec (vec),
      .prox(prox)
   );

   // NIVEL tracks the filtered vector in the same edge it is accepted.
   always_comb begin
      nivel_nx = consistente(prox) ? nivel_de(prox) : NIVEL;
      sobe     = nivel_nx > NIVEL;
      incons   = !consistente(vec) && !inc_ant;
      timeout  = fill_cnt == CNT_W'(FILL_TIMEOUT - 1);
      baixo    = !NIVEL[1];
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         estado   <= IDLE;
         VE       <= 1'b0;
         GNT_IRR  <= 1'b0;
         AL       <= 1'b1;
         ERRO     <= 1'b0;
         FLT_CODE <= NONE;
         NIVEL    <= CRIT;
         fill_cnt <= '0;
         inc_ant  <= 1'b0;
      end else begin
         NIVEL   <= nivel_nx;
         inc_ant <= !consistente(vec);
         GNT_IRR <= REQ_IRR && (NIVEL != CRIT) && (estado != FAULT);
         AL      <= (NIVEL == CRIT) || ERRO;

         if (incons) begin
            estado   <= FAULT;
            VE       <= 1'b0;
            ERRO     <= 1'b1;
            FLT_CODE <= INCONS;
            fill_cnt <= '0;
         end else begin
            case (estado)
               IDLE: begin
                  if (baixo) begin
                     estado   <= FILLING;
                     VE       <= 1'b1;
                     fill_cnt <= '0;
                  end else if (NIVEL == ALTO) begin
                     estado <= FULL;
                  end
               end
               FILLING: begin
                  if (NIVEL == ALTO) begin
                     estado <= FULL;
                     VE     <= 1'b0;
                  end else if (sobe) begin
                     fill_cnt <= '0;
                  end else if (timeout) begin
                     estado   <= FAULT;
                     VE       <= 1'b0;
                     ERRO     <= 1'b1;
                     FLT_CODE <= SECO;
                     fill_cnt <= '0;
                  end else begin
                     fill_cnt <= fill_cnt + 1'b1;
                  end
               end
               // Medium level keeps the valve shut: hysteresis band.
               FULL: begin
                  if (baixo) begin
                     estado   <= FILLING;
                     VE       <= 1'b1;
                     fill_cnt <= '0;
                  end
               end
               FAULT: begin
                  if (ACK_FLT && consistente(vec)) begin
                     estado   <= IDLE;
                     ERRO     <= 1'b0;
                     FLT_CODE <= NONE;
                  end
               end
               default: estado <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_controle_caixa.sv
// Self-checking bench for controle_caixa against a behavioural tank model.
// Expected outputs come from probe-history and level rules, not RTL state.
module tb_controle_caixa;

   localparam int DEB = 4;
   localparam int FT  = 50;
   localparam int CW  = 8;

   localparam int S_IDLE  = 0;
   localparam int S_FILL  = 1;
   localparam int S_FULL  = 2;
   localparam int S_FAULT = 3;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       H = 1'b0, M = 1'b0, L = 1'b0;
   logic       REQ_IRR = 1'b0;
   logic       ACK_FLT = 1'b0;
   logic       VE, GNT_IRR, AL, ERRO;
   logic [1:0] FLT_CODE, NIVEL;
   logic [7:0] dut_out;

   int n_chk = 0;
   int n_err = 0;

   // model state
   logic [2:0] m_q[$];
   logic [2:0] m_f, m_fp;
   logic [1:0] m_niv, m_code;
   int         m_st, m_fc;
   logic       m_ve, m_gnt, m_al, m_erro;

   always #5 CLK = ~CLK;

   controle_caixa #(
      .DEB_CYCLES  (DEB),
      .FILL_TIMEOUT(FT),
      .CNT_W       (CW)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .H       (H),
      .M       (M),
      .L       (L),
      .REQ_IRR (REQ_IRR),
      .ACK_FLT (ACK_FLT),
      .VE      (VE),
      .GNT_IRR (GNT_IRR),
      .AL      (AL),
      .ERRO    (ERRO),
      .FLT_CODE(FLT_CODE),
      .NIVEL   (NIVEL)
   );

   assign dut_out = {VE, GNT_IRR, AL, ERRO, FLT_CODE, NIVEL};

   function automatic bit cons(input logic [2:0] v);
      return (v == 3'b000) || (v == 3'b001) ||
             (v == 3'b011) || (v == 3'b111);
   endfunction

   // For a consistent vector the level is the number of wet probes.
   function automatic logic [1:0] lvl(input logic [2:0] v);
      return 2'($countones(v));
   endfunction

   function automatic logic [7:0] m_out();
      return {m_ve, m_gnt, m_al, m_erro, m_code, m_niv};
   endfunction

   task automatic m_reset();
      m_q.delete();
      for (int i = 0; i <= DEB; i++) m_q.push_back(3'b000);
      m_f = 0; m_fp = 0; m_niv = 0; m_code = 0;
      m_st = S_IDLE; m_fc = 0;
      m_ve = 0; m_gnt = 0; m_al = 1; m_erro = 0;
   endtask

   // m_q[k] is the probe sample taken k+1 edges ago.
   task automatic model_step();
      logic [2:0] nf;
      logic [1:0] nn;
      bit same, rise, trig;
      int nst;
      nf = m_f;
      same = 1;
      for (int i = 2; i <= DEB; i++) if (m_q[i] != m_q[1]) same = 0;
      if (same && m_q[1] != m_f) nf = m_q[1];
      nn = cons(nf) ? lvl(nf) : m_niv;
      rise = nn > m_niv;
      trig = !cons(m_f) && cons(m_fp);
      m_gnt = REQ_IRR && (m_niv != 0) && (m_st != S_FAULT);
      m_al = (m_niv == 0) || m_erro;
      nst = m_st;
      case (m_st)
         S_IDLE:
            if (m_niv <= 1) begin nst = S_FILL; m_fc = 0; end
            else if (m_niv == 3) nst = S_FULL;
         S_FILL:
            if (m_niv == 3) nst = S_FULL;
            else if (rise) m_fc = 0;
            else if (m_fc == FT - 1) begin
               nst = S_FAULT; m_code = 2'b10; m_erro = 1;
            end else m_fc++;
         S_FULL:
            if (m_niv <= 1) begin nst = S_FILL; m_fc = 0; end
         default:
            if (ACK_FLT && cons(m_f)) begin
               nst = S_IDLE; m_code = 0; m_erro = 0;
            end
      endcase
      if (trig) begin nst = S_FAULT; m_code = 2'b01; m_erro = 1; end
      m_ve = (nst == S_FILL);
      m_fp = m_f; m_f = nf; m_niv = nn; m_st = nst;
      m_q.push_front({H, M, L});
      void'(m_q.pop_back());
   endtask

   task automatic tick();
      @(posedge CLK);
      model_step();
      #1;
   endtask

   task automatic do_reset(input logic [2:0] v);
      RST = 1'b1;
      {H, M, L} = v;
      REQ_IRR = 1'b0;
      ACK_FLT = 1'b0;
      #3;
      m_reset();
      @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      {H, M, L} = 3'b111;
      REQ_IRR = 1'b1;
      #7;
      n_chk++;
      if (dut_out !== 8'b0010_0000) begin
         n_err++;
         $display("FAIL reset_vals dut=%b want=%b", dut_out, 8'b0010_0000);
      end
      do_reset(3'b000);
      for (int i = 1; i <= 3; i++) begin
         tick();
         n_chk++;
         if (dut_out !== m_out()) begin
            n_err++;
            $display("FAIL reset_run i=%0d dut=%b model=%b", i, dut_out, m_out());
         end
      end
   endtask

   task automatic test_fill();
      logic [2:0] seq [4];
      do_reset(3'b000);
      {H, M, L} = 3'b001;
      for (int i = 1; i <= 10; i++) begin
         tick();
         n_chk++;
         if (dut_out !== m_out()) begin
            n_err++;
            $display("FAIL fill_model i=%0d dut=%b model=%b", i, dut_out, m_out());
         end
         n_chk++;
         if (VE !== 1'b1) begin
            n_err++;
            $display("FAIL fill_ve i=%0d got=%b want=1", i, VE);
         end
         if (i == 2 + DEB - 1 || i == 2 + DEB) begin
            n_chk++;
            if (NIVEL !== ((i == 2 + DEB) ? 2'b01 : 2'b00)) begin
               n_err++;
               $display("FAIL fill_latency i=%0d nivel=%b", i, NIVEL);
            end
         end
      end
      seq[0] = 3'b011; seq[1] = 3'b111; seq[2] = 3'b011; seq[3] = 3'b001;
      for (int s = 0; s < 4; s++) begin
         {H, M, L} = seq[s];
         for (int i = 1; i <= 10; i++) begin
            tick();
            n_chk++;
            if (dut_out !== m_out()) begin
               n_err++;
               $display("FAIL fill_seq s=%0d i=%0d dut=%b model=%b", s, i, dut_out, m_out());
            end
         end
         n_chk++;
         if (VE !== ((s == 3 || s == 0) ? 1'b1 : 1'b0) || NIVEL !== lvl(seq[s])) begin
            n_err++;
            $display("FAIL fill_hyst s=%0d ve=%b nivel=%b", s, VE, NIVEL);
         end
      end
   endtask

   task automatic test_timeout();
      int first;
      first = -1;
      do_reset(3'b001);
      for (int i = 1; i <= 200 && first < 0; i++) begin
         tick();
         n_chk++;
         if (dut_out !== m_out()) begin
            n_err++;
            $display("FAIL tmo_model i=%0d dut=%b model=%b", i, dut_out, m_out());
         end
         if (ERRO === 1'b1) first = i;
      end
      n_chk++;
      if (first != 2 + DEB + FT) begin
         n_err++;
         $display("FAIL tmo_cycle got=%0d want=%0d", first, 2 + DEB + FT);
      end
      tick();
      n_chk++;
      if ({VE, AL, ERRO, FLT_CODE} !== 5'b0_1_1_10) begin
         n_err++;
         $display("FAIL tmo_flags got=%b want=01110", {VE, AL, ERRO, FLT_CODE});
      end
      ACK_FLT = 1'b1;
      tick();
      ACK_FLT = 1'b0;
      n_chk++;
      if ({VE, ERRO, FLT_CODE} !== 4'b0000) begin
         n_err++;
         $display("FAIL tmo_ack got=%b want=0000", {VE, ERRO, FLT_CODE});
      end
      tick();
      n_chk++;
      if (VE !== 1'b1 || dut_out !== m_out()) begin
         n_err++;
         $display("FAIL tmo_refill dut=%b model=%b", dut_out, m_out());
      end
   endtask

   task automatic test_incons();
      int first;
      first = -1;
      do_reset(3'b111);
      for (int i = 1; i <= 10; i++) tick();
      n_chk++;
      if (VE !== 1'b0 || NIVEL !== 2'b11 || dut_out !== m_out()) begin
         n_err++;
         $display("FAIL inc_full dut=%b model=%b", dut_out, m_out());
      end
      {H, M, L} = 3'b010;
      for (int i = 1; i <= 20 && first < 0; i++) begin
         tick();
         if (ERRO === 1'b1) first = i;
      end
      n_chk++;
      if (first != 3 + DEB || FLT_CODE !== 2'b01) begin
         n_err++;
         $display("FAIL inc_detect cyc=%0d code=%b want cyc=%0d code=01", first, FLT_CODE, 3 + DEB);
      end
      tick();
      ACK_FLT = 1'b1;
      tick();
      ACK_FLT = 1'b0;
      tick();
      n_chk++;
      if (ERRO !== 1'b1 || FLT_CODE !== 2'b01 || dut_out !== m_out()) begin
         n_err++;
         $display("FAIL inc_ack_ignored dut=%b model=%b", dut_out, m_out());
      end
      {H, M, L} = 3'b111;
      for (int i = 1; i <= 8; i++) tick();
      ACK_FLT = 1'b1;
      tick();
      ACK_FLT = 1'b0;
      n_chk++;
      if (ERRO !== 1'b0 || FLT_CODE !== 2'b00) begin
         n_err++;
         $display("FAIL inc_clear erro=%b code=%b want 0/00", ERRO, FLT_CODE);
      end
      for (int i = 1; i <= 3; i++) begin
         tick();
         n_chk++;
         if (VE !== 1'b0 || dut_out !== m_out()) begin
            n_err++;
            $display("FAIL inc_back_full i=%0d dut=%b model=%b", i, dut_out, m_out());
         end
      end
   endtask

   task automatic test_grant();
      do_reset(3'b011);
      REQ_IRR = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         n_chk++;
         if (dut_out !== m_out()) begin
            n_err++;
            $display("FAIL gnt_model i=%0d dut=%b model=%b", i, dut_out, m_out());
         end
         if (i == 2 + DEB || i == 3 + DEB) begin
            n_chk++;
            if (GNT_IRR !== (i == 3 + DEB)) begin
               n_err++;
               $display("FAIL gnt_rise i=%0d got=%b", i, GNT_IRR);
            end
         end
      end
      n_chk++;
      if (VE !== 1'b1 || GNT_IRR !== 1'b1) begin
         n_err++;
         $display("FAIL gnt_with_fill ve=%b gnt=%b want 1/1", VE, GNT_IRR);
      end
      {H, M, L} = 3'b000;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (i == 2 + DEB || i == 3 + DEB) begin
            n_chk++;
            if ({GNT_IRR, AL} !== ((i == 3 + DEB) ? 2'b01 : 2'b10)) begin
               n_err++;
               $display("FAIL gnt_fall i=%0d gnt_al=%b", i, {GNT_IRR, AL});
            end
         end
      end
      REQ_IRR = 1'b0;
   endtask

   task automatic test_glitch();
      do_reset(3'b111);
      for (int i = 1; i <= 10; i++) tick();
      {H, M, L} = 3'b011;
      for (int i = 1; i <= DEB + 8; i++) begin
         if (i == DEB) {H, M, L} = 3'b111;
         tick();
         n_chk++;
         if (NIVEL !== 2'b11 || VE !== 1'b0 || dut_out !== m_out()) begin
            n_err++;
            $display("FAIL glitch i=%0d dut=%b model=%b", i, dut_out, m_out());
         end
      end
   endtask

   task automatic test_random();
      logic [2:0] tab [4];
      int hold;
      tab[0] = 3'b000; tab[1] = 3'b001; tab[2] = 3'b011; tab[3] = 3'b111;
      do_reset(3'b000);
      for (int s = 0; s < 60; s++) begin
         if ($urandom_range(0, 7) == 0) {H, M, L} = 3'($urandom);
         else {H, M, L} = tab[$urandom_range(0, 3)];
         REQ_IRR = 1'($urandom);
         hold = $urandom_range(1, 12);
         for (int i = 0; i < hold; i++) begin
            ACK_FLT = ($urandom_range(0, 5) == 0);
            tick();
            n_chk++;
            if (dut_out !== m_out()) begin
               n_err++;
               $display("FAIL random s=%0d i=%0d in=%b dut=%b model=%b", s, i, {H, M, L}, dut_out, m_out());
            end
         end
      end
      ACK_FLT = 1'b0;
      REQ_IRR = 1'b0;
   endtask

   task automatic test_async_reset();
      do_reset(3'b000);
      for (int i = 1; i <= 3; i++) tick();
      n_chk++;
      if (VE !== 1'b1) begin
         n_err++;
         $display("FAIL arst_pre ve=%b want 1", VE);
      end
      #2;
      RST = 1'b1;
      #1;
      n_chk++;
      if (dut_out !== 8'b0010_0000) begin
         n_err++;
         $display("FAIL arst_async dut=%b want=%b", dut_out, 8'b0010_0000);
      end
      do_reset(3'b000);
   endtask

   initial begin
      test_reset();
      test_fill();
      test_timeout();
      test_incons();
      test_grant();
      test_glitch();
      test_random();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
